ajc_logic_unit_sequencer_v: RTL and testbench

- Multi-cycle controller that runs one register-to-register logic instruction at a time through the existing combinational 8-bit logic unit (ajc_8bit_logic_unit_v).
- Owns a small register file, an instruction latch, operand registers, a result register and a CNVZ flag register.
- Sequences each instruction through fetch, execute and write-back.
- Sits between instruction decode (Start handshake) and the logic datapath. It also provides an external load port and a debug read port.

---
 rtl/ajc_logic_unit_sequencer_v_if.sv | 34 +++
 rtl/ajc_logic_unit_sequencer_v.sv | 122 ++++++++++++
 tb/tb_ajc_logic_unit_sequencer_v.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ajc_logic_unit_sequencer_v_if.sv
// Bundle of issue, load and debug-read signals between the decode side
// and the logic unit sequencer.
interface ajc_logic_unit_sequencer_v_if #(
    parameter int unsigned AW = 3
);
    logic          Start;
    logic [1:0]    Op_Func;
    logic [AW-1:0] Dst_Addr;
    logic [AW-1:0] SrcX_Addr;
    logic [AW-1:0] SrcY_Addr;
    logic          Use_Imm;
    logic [7:0]    Imm_Y;
    logic          Load_En;
    logic [AW-1:0] Load_Addr;
    logic [7:0]    Load_Data;
    logic [AW-1:0] Rd_Addr;
    logic [7:0]    Rd_Data;
    logic          Busy;
    logic          Done;
    logic [7:0]    Result;
    logic [3:0]    CNVZ;

    modport master (
        output Start, Op_Func, Dst_Addr, SrcX_Addr, SrcY_Addr, Use_Imm, Imm_Y,
               Load_En, Load_Addr, Load_Data, Rd_Addr,
        input  Rd_Data, Busy, Done, Result, CNVZ
    );

    modport slave (
        input  Start, Op_Func, Dst_Addr, SrcX_Addr, SrcY_Addr, Use_Imm, Imm_Y,
               Load_En, Load_Addr, Load_Data, Rd_Addr,
        output Rd_Data, Busy, Done, Result, CNVZ
    );
endinterface

// File: rtl/ajc_logic_unit_sequencer_v.sv
// Multi-cycle sequencer running one register-to-register logic instruction
// at a time: IDLE -> FETCH -> EXEC -> WB. Owns the register file, the
// instruction latch, operand/result registers and the CNVZ flag register.
module ajc_logic_unit_sequencer_v #(
    parameter int unsigned NREG = 8,
    parameter int unsigned AW   = 3
) (
    input  logic                         i_Clock,
    input  logic                         i_Reset,
    ajc_logic_unit_sequencer_v_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WB
    } state_t;

    state_t        r_state;
    logic [7:0]    r_regs [NREG];

    logic [1:0]    r_op;
    logic [AW-1:0] r_dst;
    logic [AW-1:0] r_srcx;
    logic [AW-1:0] r_srcy;
    logic          r_use_imm;
    logic [7:0]    r_imm;

    logic [7:0]    r_opx;
    logic [7:0]    r_opy;
    logic [7:0]    r_result;
    logic [3:0]    r_pend;
    logic [3:0]    r_cnvz;
    logic          r_busy;
    logic          r_done;

    logic [7:0]    w_lu_res;
    logic [3:0]    w_lu_flags;

    // 8-bit logic unit: XOR / AND / OR / pass X; C and V are always clear
    always_comb begin
        w_lu_res = '0;
        unique case (r_op)
            2'd0: w_lu_res = r_opx ^ r_opy;
            2'd1: w_lu_res = r_opx & r_opy;
            2'd2: w_lu_res = r_opx | r_opy;
            2'd3: w_lu_res = r_opx;
            default: w_lu_res = '0;
        endcase
        w_lu_flags = {1'b0, w_lu_res[7], 1'b0, (w_lu_res == 8'h00)};
    end

    // Sequencer FSM with register file, latches and registered status outputs
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_dst     <= '0;
            r_srcx    <= '0;
            r_srcy    <= '0;
            r_use_imm <= 1'b0;
            r_imm     <= '0;
            r_opx     <= '0;
            r_opy     <= '0;
            r_result  <= '0;
            r_pend    <= '0;
            r_cnvz    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // External load lands at this edge, so a same-cycle issue
                    // sees it one cycle later in FETCH.
                    if (bus.Load_En) begin
                        r_regs[bus.Load_Addr] <= bus.Load_Data;
                    end
                    if (bus.Start) begin
                        r_op      <= bus.Op_Func;
                        r_dst     <= bus.Dst_Addr;
                        r_srcx    <= bus.SrcX_Addr;
                        r_srcy    <= bus.SrcY_Addr;
                        r_use_imm <= bus.Use_Imm;
                        r_imm     <= bus.Imm_Y;
                        r_busy    <= 1'b1;
                        r_state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_opx   <= r_regs[r_srcx];
                    r_opy   <= r_use_imm ? r_imm : r_regs[r_srcy];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_result <= w_lu_res;
                    r_pend   <= w_lu_flags;
                    r_done   <= 1'b1;
                    r_state  <= S_WB;
                end
                S_WB: begin
                    r_regs[r_dst] <= r_result;
                    r_cnvz        <= r_pend;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.Rd_Data = r_regs[bus.Rd_Addr];
    assign bus.Busy    = r_busy;
    assign bus.Done    = r_done;
    assign bus.Result  = r_result;
    assign bus.CNVZ    = r_cnvz;

endmodule

// File: tb/tb_ajc_logic_unit_sequencer_v.sv
// Scoreboard bench for the logic unit sequencer: directed instructions push
// their expected result/flags/Done cycle; a monitor checks every Done pulse.
module tb_ajc_logic_unit_sequencer_v;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_fail;
    int   done_cnt;

    typedef struct {
        logic [7:0] res;
        logic [3:0] flags;
        int         done_cyc;
    } exp_t;

    exp_t sbq[$];

    ajc_logic_unit_sequencer_v_if #(.AW(3)) bus ();

    ajc_logic_unit_sequencer_v #(.NREG(8), .AW(3)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: compare each Done pulse against the scoreboard, then the flags
    // one cycle later once write-back has landed.
    logic       flag_pend = 1'b0;
    logic [3:0] flag_exp;
    always @(negedge clk) begin
        exp_t e;
        if (flag_pend) begin
            chk("cnvz_after_wb", int'(bus.CNVZ), int'(flag_exp));
            flag_pend = 1'b0;
        end
        if (!rst && bus.Done) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("result", int'(bus.Result), int'(e.res));
                chk("busy_in_wb", int'(bus.Busy), 1);
                flag_exp  = e.flags;
                flag_pend = 1'b1;
            end
        end
    end

    task automatic rd(input logic [2:0] a, input logic [7:0] exp_v);
        bus.Rd_Addr = a;
        #1;
        chk($sformatf("reg[%0d]", a), int'(bus.Rd_Data), int'(exp_v));
    endtask

    task automatic load(input logic [2:0] a, input logic [7:0] d);
        bus.Load_En   = 1'b1;
        bus.Load_Addr = a;
        bus.Load_Data = d;
        @(negedge clk);
        bus.Load_En   = 1'b0;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] x,
                          input logic [2:0] y, input logic ui, input logic [7:0] imm);
        bus.Op_Func   = op;
        bus.Dst_Addr  = dst;
        bus.SrcX_Addr = x;
        bus.SrcY_Addr = y;
        bus.Use_Imm   = ui;
        bus.Imm_Y     = imm;
    endtask

    // Issue one instruction (optionally with a same-cycle load) and wait
    // until the sequencer is back in IDLE.
    task automatic issue(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] x,
                         input logic [2:0] y, input logic ui, input logic [7:0] imm,
                         input logic le, input logic [2:0] la, input logic [7:0] ld,
                         input logic [7:0] eres, input logic [3:0] eflags);
        set_op(op, dst, x, y, ui, imm);
        bus.Start     = 1'b1;
        bus.Load_En   = le;
        bus.Load_Addr = la;
        bus.Load_Data = ld;
        sbq.push_back('{eres, eflags, cyc + 3});
        @(negedge clk);
        bus.Start   = 1'b0;
        bus.Load_En = 1'b0;
        chk("busy_in_fetch", int'(bus.Busy), 1);
        chk("no_done_in_fetch", int'(bus.Done), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        cyc = 0; n_chk = 0; n_fail = 0; done_cnt = 0;
        rst = 1'b1;
        bus.Start = 1'b0; bus.Load_En = 1'b0; bus.Load_Addr = '0; bus.Load_Data = '0;
        bus.Rd_Addr = '0;
        set_op(2'd0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: reset state
        chk("busy_reset", int'(bus.Busy), 0);
        chk("done_reset", int'(bus.Done), 0);
        chk("cnvz_reset", int'(bus.CNVZ), 0);
        chk("result_reset", int'(bus.Result), 0);
        for (int i = 0; i < 8; i++) rd(3'(i), 8'h00);

        // 2: XOR r1^r2 -> r3
        @(negedge clk);
        load(3'd1, 8'hF0);
        load(3'd2, 8'h3C);
        issue(2'd0, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'hCC, 4'b0100);
        rd(3'd3, 8'hCC);

        // 3: AND with immediate, OR with immediate, MOV
        @(negedge clk);
        load(3'd1, 8'h0F);
        issue(2'd1, 3'd1, 3'd1, 3'd7, 1'b1, 8'hF0, 1'b0, 3'd0, 8'h00, 8'h00, 4'b0001);
        rd(3'd1, 8'h00);
        issue(2'd2, 3'd1, 3'd1, 3'd7, 1'b1, 8'h80, 1'b0, 3'd0, 8'h00, 8'h80, 4'b0100);
        rd(3'd1, 8'h80);
        issue(2'd3, 3'd4, 3'd1, 3'd2, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h80, 4'b0100);
        rd(3'd4, 8'h80);

        // 4: Start in FETCH/EXEC and Load in WB are ignored
        @(negedge clk);
        d0 = done_cnt;
        set_op(2'd2, 3'd0, 3'd1, 3'd2, 1'b0, 8'h00);
        bus.Start = 1'b1;
        sbq.push_back('{8'hBC, 4'b0100, cyc + 3});
        @(negedge clk);
        set_op(2'd3, 3'd5, 3'd1, 3'd2, 1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        bus.Start     = 1'b0;
        bus.Load_En   = 1'b1;
        bus.Load_Addr = 3'd5;
        bus.Load_Data = 8'h99;
        @(negedge clk);
        bus.Load_En = 1'b0;
        repeat (4) @(negedge clk);
        chk("done_count_ignored_start", done_cnt - d0, 1);
        rd(3'd5, 8'h00);
        rd(3'd0, 8'hBC);

        // 5: same-cycle load and start, then Start held for 8 cycles
        @(negedge clk);
        load(3'd6, 8'h11);
        issue(2'd0, 3'd6, 3'd5, 3'd5, 1'b0, 8'h00, 1'b1, 3'd5, 8'h55, 8'h00, 4'b0001);
        rd(3'd6, 8'h00);
        rd(3'd5, 8'h55);
        issue(2'd3, 3'd4, 3'd7, 3'd0, 1'b0, 8'h00, 1'b1, 3'd7, 8'h66, 8'h66, 4'b0000);
        rd(3'd4, 8'h66);
        d0 = done_cnt;
        set_op(2'd0, 3'd5, 3'd5, 3'd0, 1'b1, 8'h0A);
        bus.Start = 1'b1;
        sbq.push_back('{8'h5F, 4'b0000, cyc + 3});
        sbq.push_back('{8'h55, 4'b0000, cyc + 7});
        repeat (8) @(negedge clk);
        bus.Start = 1'b0;
        repeat (2) @(negedge clk);
        chk("done_count_held_start", done_cnt - d0, 2);
        rd(3'd5, 8'h55);

        // 6: reset during EXEC aborts, then re-run
        @(negedge clk);
        load(3'd3, 8'hAA);
        d0 = done_cnt;
        set_op(2'd3, 3'd2, 3'd3, 3'd0, 1'b0, 8'h00);
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("busy_after_abort", int'(bus.Busy), 0);
        chk("done_after_abort", int'(bus.Done), 0);
        chk("cnvz_after_abort", int'(bus.CNVZ), 0);
        rd(3'd2, 8'h00);
        rd(3'd3, 8'h00);
        repeat (3) @(negedge clk);
        chk("done_count_abort", done_cnt - d0, 0);
        load(3'd3, 8'hAA);
        issue(2'd3, 3'd2, 3'd3, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'hAA, 4'b0100);
        rd(3'd2, 8'hAA);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
